ulpb_node_rx: RTL and testbench

Bus-member receive front end for the ULPB ring. It sits directly downstream of the ULPB bus controller and consumes the controller's bus clock and data, arriving on CLKIN/DIN. The block oversamples both wires with its local clock and tracks the message: start, arbitration, priority, 8-bit address, 32-bit data words, interrupt, and two control bits. It delivers address, words and end-of-message status to the node's layer logic.

---
 rtl/ulpb_node_rx.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ulpb_node_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ulpb_node_rx.sv
// rtl/ulpb_node_rx.sv - ULPB bus-member receive front end: oversampled CLKIN/DIN message tracker
module ulpb_node_rx #(
    parameter logic [7:0] ADDRESS    = 8'hA5,
    parameter int         INT_THRESH = 6
) (
    input  logic        CLK_EXT,
    input  logic        RESETn,
    input  logic        CLKIN,
    input  logic        DIN,
    output logic [7:0]  RX_ADDR,
    output logic        RX_ADDR_VLD,
    output logic        RX_ADDR_MATCH,
    output logic [31:0] RX_DATA,
    output logic        RX_DATA_VLD,
    output logic [1:0]  RX_CTRL,
    output logic        RX_DONE,
    output logic        RX_FAIL,
    output logic        BUS_BUSY
);

    localparam int HI_W = $clog2(INT_THRESH + 1);
    localparam logic [HI_W-1:0] HI_MAX = HI_W'(INT_THRESH);

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_PRIO, S_ADDR, S_DATA, S_INT_WAIT,
        S_SKIP0, S_SKIP1, S_CTRL0, S_CTRL1, S_END
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic            r_clk_m, r_clk_s, r_clk_d;
    logic            r_din_m, r_din_s, r_din_d;
    logic [HI_W-1:0] r_hi_cnt;
    logic [1:0]      r_edge_cnt;
    logic [4:0]      r_bit_cnt;
    logic [31:0]     r_shift;
    logic [7:0]      r_rx_addr;
    logic [31:0]     r_rx_data;
    logic [1:0]      r_ctrl;
    logic            r_addr_vld, r_data_vld, r_match, r_done, r_fail, r_busy;
    logic            r_fail_flag, r_word_seen, r_c0;

    logic            w_re, w_din_fall, w_int_det, w_int_window, w_bad_end;
    logic [31:0]     w_shift_word;
    logic            w_start, w_clr_cnt, w_shift, w_addr_load, w_data_load;
    logic            w_int_take, w_cap_c0, w_msg_end, w_go_idle;

    always_ff @(posedge CLK_EXT or negedge RESETn) begin
        if (!RESETn) begin
            r_clk_m <= 1'b0;
            r_clk_s <= 1'b0;
            r_clk_d <= 1'b0;
            r_din_m <= 1'b0;
            r_din_s <= 1'b0;
            r_din_d <= 1'b0;
        end else begin
            r_clk_m <= CLKIN;
            r_clk_s <= r_clk_m;
            r_clk_d <= r_clk_s;
            r_din_m <= DIN;
            r_din_s <= r_din_m;
            r_din_d <= r_din_s;
        end
    end

    assign w_re         = r_clk_s & ~r_clk_d;
    assign w_din_fall   = r_clk_s & r_din_d & ~r_din_s;
    assign w_shift_word = {r_shift[30:0], r_din_s};

    // Interrupt signature: CLKIN stretched high while DIN toggles at least three times.
    always_ff @(posedge CLK_EXT or negedge RESETn) begin
        if (!RESETn) begin
            r_hi_cnt   <= '0;
            r_edge_cnt <= 2'd0;
        end else if (!r_clk_s) begin
            r_hi_cnt   <= '0;
            r_edge_cnt <= 2'd0;
        end else begin
            if (r_hi_cnt != HI_MAX) begin
                r_hi_cnt <= r_hi_cnt + 1'b1;
            end
            if ((r_din_s != r_din_d) && (r_edge_cnt != 2'd3)) begin
                r_edge_cnt <= r_edge_cnt + 2'd1;
            end
        end
    end

    assign w_int_det    = (r_hi_cnt == HI_MAX) && (r_edge_cnt == 2'd3);
    assign w_int_window = (r_state == S_ARB) || (r_state == S_PRIO) ||
                          (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_bad_end    = (r_state != S_DATA) || (r_bit_cnt != 5'd0) || !r_word_seen;

    always_ff @(posedge CLK_EXT or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_clr_cnt    = 1'b0;
        w_shift      = 1'b0;
        w_addr_load  = 1'b0;
        w_data_load  = 1'b0;
        w_int_take   = 1'b0;
        w_cap_c0     = 1'b0;
        w_msg_end    = 1'b0;
        w_go_idle    = 1'b0;
        // An interrupt overrides a coincident bit edge; that bit is dropped.
        if (w_int_window && w_int_det) begin
            w_int_take   = 1'b1;
            w_state_next = S_INT_WAIT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_din_fall) begin
                        w_start      = 1'b1;
                        w_state_next = S_ARB;
                    end
                end
                S_ARB: begin
                    if (w_re) begin
                        w_state_next = S_PRIO;
                    end
                end
                S_PRIO: begin
                    if (w_re) begin
                        w_clr_cnt    = 1'b1;
                        w_state_next = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_re) begin
                        w_shift = 1'b1;
                        if (r_bit_cnt == 5'd7) begin
                            w_addr_load  = 1'b1;
                            w_state_next = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_re) begin
                        w_shift     = 1'b1;
                        w_data_load = (r_bit_cnt == 5'd31);
                    end
                end
                S_INT_WAIT: begin
                    if (w_re) begin
                        w_state_next = S_SKIP0;
                    end
                end
                S_SKIP0: begin
                    if (w_re) begin
                        w_state_next = S_SKIP1;
                    end
                end
                S_SKIP1: begin
                    if (w_re) begin
                        w_state_next = S_CTRL0;
                    end
                end
                S_CTRL0: begin
                    if (w_re) begin
                        w_cap_c0     = 1'b1;
                        w_state_next = S_CTRL1;
                    end
                end
                S_CTRL1: begin
                    if (w_re) begin
                        w_msg_end    = 1'b1;
                        w_state_next = S_END;
                    end
                end
                S_END: begin
                    if (r_clk_s && r_din_s) begin
                        w_go_idle    = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_EXT or negedge RESETn) begin
        if (!RESETn) begin
            r_bit_cnt   <= 5'd0;
            r_shift     <= 32'd0;
            r_rx_addr   <= 8'd0;
            r_rx_data   <= 32'd0;
            r_ctrl      <= 2'd0;
            r_addr_vld  <= 1'b0;
            r_data_vld  <= 1'b0;
            r_match     <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_busy      <= 1'b0;
            r_fail_flag <= 1'b0;
            r_word_seen <= 1'b0;
            r_c0        <= 1'b0;
        end else begin
            r_addr_vld <= w_addr_load;
            r_data_vld <= w_data_load & r_match;
            r_done     <= w_msg_end & ~r_fail_flag;
            r_fail     <= w_msg_end & r_fail_flag;
            if (w_start) begin
                r_busy      <= 1'b1;
                r_fail_flag <= 1'b0;
                r_word_seen <= 1'b0;
                r_match     <= 1'b0;
            end
            if (w_clr_cnt) begin
                r_bit_cnt <= 5'd0;
            end
            // bit_cnt wraps naturally at 32 in DATA; it restarts after the address byte.
            if (w_shift) begin
                r_shift   <= w_shift_word;
                r_bit_cnt <= w_addr_load ? 5'd0 : r_bit_cnt + 5'd1;
            end
            if (w_addr_load) begin
                r_rx_addr <= w_shift_word[7:0];
                r_match   <= (w_shift_word[7:0] == ADDRESS);
            end
            if (w_data_load) begin
                r_word_seen <= 1'b1;
                if (r_match) begin
                    r_rx_data <= w_shift_word;
                end
            end
            if (w_int_take) begin
                r_fail_flag <= r_fail_flag | w_bad_end;
            end
            if (w_cap_c0) begin
                r_c0 <= r_din_s;
            end
            if (w_msg_end) begin
                r_ctrl <= {r_c0, r_din_s};
            end
            if (w_go_idle) begin
                r_busy      <= 1'b0;
                r_fail_flag <= 1'b0;
                r_match     <= 1'b0;
            end
        end
    end

    assign RX_ADDR       = r_rx_addr;
    assign RX_ADDR_VLD   = r_addr_vld;
    assign RX_ADDR_MATCH = r_match;
    assign RX_DATA       = r_rx_data;
    assign RX_DATA_VLD   = r_data_vld;
    assign RX_CTRL       = r_ctrl;
    assign RX_DONE       = r_done;
    assign RX_FAIL       = r_fail;
    assign BUS_BUSY      = r_busy;

endmodule

// File: tb/tb_ulpb_node_rx.sv
// tb/tb_ulpb_node_rx.sv - table-driven bench for ulpb_node_rx
module tb_ulpb_node_rx;

    logic        CLK_EXT = 1'b0;
    logic        RESETn  = 1'b0;
    logic        CLKIN   = 1'b1;
    logic        DIN     = 1'b1;
    logic [7:0]  RX_ADDR;
    logic        RX_ADDR_VLD;
    logic        RX_ADDR_MATCH;
    logic [31:0] RX_DATA;
    logic        RX_DATA_VLD;
    logic [1:0]  RX_CTRL;
    logic        RX_DONE;
    logic        RX_FAIL;
    logic        BUS_BUSY;

    ulpb_node_rx dut (
        .CLK_EXT       (CLK_EXT),
        .RESETn        (RESETn),
        .CLKIN         (CLKIN),
        .DIN           (DIN),
        .RX_ADDR       (RX_ADDR),
        .RX_ADDR_VLD   (RX_ADDR_VLD),
        .RX_ADDR_MATCH (RX_ADDR_MATCH),
        .RX_DATA       (RX_DATA),
        .RX_DATA_VLD   (RX_DATA_VLD),
        .RX_CTRL       (RX_CTRL),
        .RX_DONE       (RX_DONE),
        .RX_FAIL       (RX_FAIL),
        .BUS_BUSY      (BUS_BUSY)
    );

    always #5 CLK_EXT = ~CLK_EXT;

    typedef struct {
        logic [7:0]  addr;
        int          abits;
        int          dbits;
        logic [63:0] data;
        logic        c0;
        logic        c1;
        int          tog;
        int          e_avld;
        logic        e_match;
        int          e_dvld;
        logic [31:0] e_word;
        int          e_done;
        int          e_fail;
        logic [1:0]  e_ctrl;
    } vec_t;

    vec_t vecs[7];

    int n_checks = 0;
    int n_errors = 0;

    int          n_avld = 0;
    int          n_dvld = 0;
    int          n_done = 0;
    int          n_fail = 0;
    int          n_wide = 0;
    logic [7:0]  s_addr = 8'd0;
    logic        s_match = 1'b0;
    logic [31:0] s_word = 32'd0;
    logic [3:0]  p_prev = 4'd0;

    always @(negedge CLK_EXT) begin
        if (RX_ADDR_VLD) begin
            n_avld  <= n_avld + 1;
            s_addr  <= RX_ADDR;
            s_match <= RX_ADDR_MATCH;
        end
        if (RX_DATA_VLD) begin
            n_dvld <= n_dvld + 1;
            s_word <= RX_DATA;
        end
        if (RX_DONE) n_done <= n_done + 1;
        if (RX_FAIL) n_fail <= n_fail + 1;
        p_prev <= {RX_ADDR_VLD, RX_DATA_VLD, RX_DONE, RX_FAIL};
        if ((p_prev & {RX_ADDR_VLD, RX_DATA_VLD, RX_DONE, RX_FAIL}) != 4'd0) begin
            n_wide <= n_wide + 1;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int hi, input bit tog);
        CLKIN = 1'b0;
        DIN   = b;
        repeat (4) @(negedge CLK_EXT);
        CLKIN = 1'b1;
        if (tog) begin
            @(negedge CLK_EXT); DIN = ~b;
            @(negedge CLK_EXT); DIN = b;
            @(negedge CLK_EXT); DIN = ~b;
            repeat (hi - 3) @(negedge CLK_EXT);
        end else begin
            repeat (hi) @(negedge CLK_EXT);
        end
    endtask

    task automatic bus_start();
        DIN = 1'b0;
        repeat (4) @(negedge CLK_EXT);
    endtask

    task automatic bus_idle();
        DIN   = 1'b1;
        CLKIN = 1'b1;
        repeat (10) @(negedge CLK_EXT);
    endtask

    task automatic send_interrupt(input logic c0, input logic c1);
        for (int k = 0; k < 4; k++) begin
            DIN = ~DIN;
            repeat (2) @(negedge CLK_EXT);
        end
        repeat (4) @(negedge CLK_EXT);
        send_bit(1'b0, 4, 1'b0);
        send_bit(1'b0, 4, 1'b0);
        send_bit(1'b0, 4, 1'b0);
        send_bit(c0, 4, 1'b0);
        send_bit(c1, 4, 1'b0);
    endtask

    task automatic run_msg(input vec_t v, input int idx);
        int a0, d0, dn0, f0;
        a0  = n_avld;
        d0  = n_dvld;
        dn0 = n_done;
        f0  = n_fail;
        bus_start();
        send_bit(1'b0, 4, 1'b0);
        check($sformatf("v%0d_busy_mid", idx), 64'(BUS_BUSY), 64'd1);
        send_bit(1'b1, 4, 1'b0);
        for (int i = 0; i < v.abits; i++) send_bit(v.addr[7-i], 4, 1'b0);
        if (v.abits == 8) check($sformatf("v%0d_addr_vld_latency", idx), 64'(n_avld - a0), 64'(v.e_avld));
        for (int i = 0; i < v.dbits; i++) begin
            send_bit(v.data[63-i], (i == v.tog) ? 5 : 4, i == v.tog);
        end
        send_interrupt(v.c0, v.c1);
        bus_idle();
        check($sformatf("v%0d_addr_vld_count", idx), 64'(n_avld - a0), 64'(v.e_avld));
        if (v.e_avld > 0) begin
            check($sformatf("v%0d_rx_addr", idx), 64'(s_addr), 64'(v.addr));
            check($sformatf("v%0d_addr_match", idx), 64'(s_match), 64'(v.e_match));
        end
        check($sformatf("v%0d_data_vld_count", idx), 64'(n_dvld - d0), 64'(v.e_dvld));
        if (v.e_dvld > 0) check($sformatf("v%0d_rx_data", idx), 64'(s_word), 64'(v.e_word));
        check($sformatf("v%0d_done_count", idx), 64'(n_done - dn0), 64'(v.e_done));
        check($sformatf("v%0d_fail_count", idx), 64'(n_fail - f0), 64'(v.e_fail));
        check($sformatf("v%0d_rx_ctrl", idx), 64'(RX_CTRL), 64'(v.e_ctrl));
        check($sformatf("v%0d_busy_idle", idx), 64'(BUS_BUSY), 64'd0);
        check($sformatf("v%0d_match_idle", idx), 64'(RX_ADDR_MATCH), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int a0, d0, dn0, f0;
        //          addr   ab  db  data                       c0    c1  tog avld match dvld word          done fail ctrl
        vecs[0] = '{8'hA5, 8, 32, {32'hDEADBEEF, 32'h0},     1'b1, 1'b0, -1, 1, 1'b1, 1, 32'hDEADBEEF, 1, 0, 2'b10};
        vecs[1] = '{8'h3C, 8, 64, 64'h01234567_89ABCDEF,     1'b0, 1'b1, -1, 1, 1'b0, 0, 32'h0,        1, 0, 2'b01};
        vecs[2] = '{8'hA5, 8, 40, {32'hCAFEF00D, 32'h5A000000}, 1'b1, 1'b1, -1, 1, 1'b1, 1, 32'hCAFEF00D, 0, 1, 2'b11};
        vecs[3] = '{8'hA5, 5, 0,  64'h0,                     1'b0, 1'b1, -1, 0, 1'b0, 0, 32'h0,        0, 1, 2'b01};
        vecs[4] = '{8'hA5, 8, 32, {32'h0F0F1234, 32'h0},     1'b0, 1'b0, 10, 1, 1'b1, 1, 32'h0F0F1234, 1, 0, 2'b00};
        vecs[5] = '{8'hA5, 8, 0,  64'h0,                     1'b1, 1'b0, -1, 1, 1'b1, 0, 32'h0,        0, 1, 2'b10};
        vecs[6] = '{8'hA5, 8, 64, 64'h11223344_55667788,     1'b1, 1'b1, -1, 1, 1'b1, 2, 32'h55667788, 1, 0, 2'b11};

        repeat (4) @(negedge CLK_EXT);
        check("reset_outputs", 64'({RX_ADDR, RX_ADDR_VLD, RX_ADDR_MATCH, RX_DATA, RX_DATA_VLD,
                                    RX_CTRL, RX_DONE, RX_FAIL, BUS_BUSY}), 64'd0);
        RESETn = 1'b1;
        bus_idle();
        check("idle_busy_after_reset", 64'(BUS_BUSY), 64'd0);

        for (int k = 0; k < 7; k++) run_msg(vecs[k], k);

        // Reset in the middle of a data word, then junk bits that must be ignored.
        bus_start();
        send_bit(1'b0, 4, 1'b0);
        send_bit(1'b1, 4, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(vecs[0].addr[7-i], 4, 1'b0);
        for (int i = 0; i < 20; i++) send_bit(i[0], 4, 1'b0);
        check("pre_reset_busy", 64'(BUS_BUSY), 64'd1);
        #2;
        RESETn = 1'b0;
        #1;
        check("midmsg_reset_addr", 64'(RX_ADDR), 64'd0);
        check("midmsg_reset_data", 64'(RX_DATA), 64'd0);
        check("midmsg_reset_ctrl_match_busy", 64'({RX_CTRL, RX_ADDR_MATCH, BUS_BUSY}), 64'd0);
        repeat (3) @(negedge CLK_EXT);
        RESETn = 1'b1;
        a0  = n_avld;
        d0  = n_dvld;
        dn0 = n_done;
        f0  = n_fail;
        for (int i = 0; i < 12; i++) send_bit(i[1], 4, 1'b0);
        check("post_reset_ignored_busy", 64'(BUS_BUSY), 64'd0);
        check("post_reset_ignored_pulses", 64'((n_avld - a0) + (n_dvld - d0) + (n_done - dn0) + (n_fail - f0)), 64'd0);
        bus_idle();
        run_msg(vecs[0], 7);

        check("pulse_width", 64'(n_wide), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
